// File: rtl/bcd_time_keeper.sv
// bcd_time_keeper: 24 h BCD time-of-day counter with alarm time and set-button handling
module bcd_time_keeper #(
    parameter int          CLK_DIV     = 50000000,
    parameter logic [15:0] ALARM_RESET = 16'h0600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_time,
    input  logic        set_alarm,
    input  logic        inc_hour,
    input  logic        inc_min,
    output logic [15:0] current_time,
    output logic [15:0] alarm_time,
    output logic [7:0]  seconds,
    output logic        one_minute
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    function automatic logic [7:0] inc60(input logic [7:0] v);
        return v == 8'h59 ? 8'h00 : v[3:0] == 4'h9 ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
    endfunction

    function automatic logic [7:0] inc24(input logic [7:0] v);
        return v == 8'h23 ? 8'h00 : v[3:0] == 4'h9 ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    sec_q, sec_d;
    logic [15:0]   time_q, time_d, alarm_q, alarm_d;
    logic          one_minute_q, one_minute_d;
    logic          arm_h_q, arm_h_d, arm_m_q, arm_m_d;
    logic          tick, edge_h, edge_m, sec_wrap, min_wrap, alarm_ed;

    // arm_*_q is set only after a button has been seen low, so a press held through reset is ignored
    always_comb begin
        tick         = !set_time && presc_q == LAST;
        edge_h       = inc_hour && arm_h_q;
        edge_m       = inc_min && arm_m_q;
        sec_wrap     = tick && sec_q == 8'h59;
        min_wrap     = sec_wrap && time_q[7:0] == 8'h59;
        alarm_ed     = set_alarm && !set_time;
        presc_d      = (set_time || tick) ? '0 : presc_q + PW'(1);
        sec_d        = set_time ? 8'h00 : tick ? inc60(sec_q) : sec_q;
        time_d       = {(set_time ? edge_h : min_wrap) ? inc24(time_q[15:8]) : time_q[15:8],
                        (set_time ? edge_m : sec_wrap) ? inc60(time_q[7:0]) : time_q[7:0]};
        alarm_d      = {(alarm_ed && edge_h) ? inc24(alarm_q[15:8]) : alarm_q[15:8],
                        (alarm_ed && edge_m) ? inc60(alarm_q[7:0]) : alarm_q[7:0]};
        one_minute_d = sec_wrap;
        arm_h_d      = !inc_hour;
        arm_m_d      = !inc_min;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q      <= '0;
            sec_q        <= 8'h00;
            time_q       <= 16'h0000;
            alarm_q      <= ALARM_RESET;
            one_minute_q <= 1'b0;
            arm_h_q      <= 1'b0;
            arm_m_q      <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            sec_q        <= sec_d;
            time_q       <= time_d;
            alarm_q      <= alarm_d;
            one_minute_q <= one_minute_d;
            arm_h_q      <= arm_h_d;
            arm_m_q      <= arm_m_d;
        end
    end

    assign current_time = time_q;
    assign alarm_time   = alarm_q;
    assign seconds      = sec_q;
    assign one_minute   = one_minute_q;
endmodule

// File: tb/tb_bcd_time_keeper.sv
// tb_bcd_time_keeper: randomized and directed checks against an integer time-of-day model
module tb_bcd_time_keeper;
    localparam int DIV = 4;

    logic        clk = 1'b0, reset = 1'b1, set_time = 1'b0, set_alarm = 1'b0;
    logic        inc_hour = 1'b0, inc_min = 1'b0;
    logic [15:0] current_time, alarm_time;
    logic [7:0]  seconds;
    logic        one_minute;
    int          tests = 0, fails = 0;

    int m_h, m_m, m_s, m_cnt, m_ah, m_am;
    bit m_pulse, m_ph, m_pm;

    always #5 clk = ~clk;

    bcd_time_keeper #(.CLK_DIV(DIV), .ALARM_RESET(16'h0600)) dut (
        .clk(clk), .reset(reset), .set_time(set_time), .set_alarm(set_alarm),
        .inc_hour(inc_hour), .inc_min(inc_min), .current_time(current_time),
        .alarm_time(alarm_time), .seconds(seconds), .one_minute(one_minute)
    );

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [15:0] hhmm(input int h, input int m);
        return {bcd(h), bcd(m)};
    endfunction

    // Reference: time of day as seconds since midnight, buttons as "was it down last cycle"
    always @(posedge clk) begin
        automatic int h = m_h, mi = m_m, s = m_s, c = m_cnt, ah = m_ah, am = m_am;
        automatic int tod;
        automatic bit p = 1'b0;
        automatic bit eh = inc_hour && !m_ph;
        automatic bit em = inc_min && !m_pm;
        if (reset) begin
            h = 0; mi = 0; s = 0; c = 0; ah = 6; am = 0;
        end else if (set_time) begin
            c = 0; s = 0;
            if (eh) h = (h + 1) % 24;
            if (em) mi = (mi + 1) % 60;
        end else begin
            if (set_alarm) begin
                if (eh) ah = (ah + 1) % 24;
                if (em) am = (am + 1) % 60;
            end
            if (c == DIV - 1) begin
                c = 0;
                tod = (h * 3600 + mi * 60 + s + 1) % 86400;
                h = tod / 3600; mi = (tod / 60) % 60; s = tod % 60;
                p = (s == 0);
            end else c++;
        end
        m_h <= h; m_m <= mi; m_s <= s; m_cnt <= c; m_ah <= ah; m_am <= am;
        m_pulse <= p;
        m_ph <= reset ? 1'b1 : inc_hour;
        m_pm <= reset ? 1'b1 : inc_min;
    end

    task automatic press(input logic h, input logic m);
        inc_hour = h; inc_min = m;
        @(negedge clk);
        inc_hour = 1'b0; inc_min = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (current_time !== 16'h0000) begin fails++; $display("FAIL reset_time: got %h want 0000", current_time); end
        tests++; if (seconds !== 8'h00) begin fails++; $display("FAIL reset_sec: got %h want 00", seconds); end
        tests++; if (alarm_time !== 16'h0600) begin fails++; $display("FAIL reset_alarm: got %h want 0600", alarm_time); end
        tests++; if (one_minute !== 1'b0) begin fails++; $display("FAIL reset_pulse: got %b want 0", one_minute); end
        reset = 1'b0;
    endtask

    task automatic test_run_minute();
        int pulses = 0;
        repeat (240) begin
            @(negedge clk);
            if (one_minute) pulses++;
            tests++; if (one_minute !== m_pulse) begin fails++; $display("FAIL run_pulse: got %b want %b", one_minute, m_pulse); end
        end
        tests++; if (current_time !== 16'h0001) begin fails++; $display("FAIL run_time: got %h want 0001", current_time); end
        tests++; if (seconds !== 8'h00) begin fails++; $display("FAIL run_sec: got %h want 00", seconds); end
        tests++; if (pulses != 1) begin fails++; $display("FAIL run_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_rollover();
        int nh, nm, pulses = 0;
        set_time = 1'b1;
        @(negedge clk);
        nh = (23 - m_h + 24) % 24;
        nm = (59 - m_m + 60) % 60;
        repeat (nh) press(1'b1, 1'b0);
        repeat (nm) press(1'b0, 1'b1);
        tests++; if (current_time !== 16'h2359) begin fails++; $display("FAIL preset_time: got %h want 2359", current_time); end
        tests++; if (seconds !== 8'h00) begin fails++; $display("FAIL preset_sec: got %h want 00", seconds); end
        set_time = 1'b0;
        for (int i = 0; i < 60 * DIV; i++) begin
            @(negedge clk);
            if (one_minute) pulses++;
            if (i == DIV - 2) begin
                tests++; if (seconds !== 8'h00) begin fails++; $display("FAIL resume_early: got %h want 00", seconds); end
            end
            if (i == DIV - 1) begin
                tests++; if (seconds !== 8'h01) begin fails++; $display("FAIL resume_tick: got %h want 01", seconds); end
            end
        end
        tests++; if (current_time !== 16'h0000) begin fails++; $display("FAIL wrap_time: got %h want 0000", current_time); end
        tests++; if (one_minute !== 1'b1) begin fails++; $display("FAIL wrap_pulse: got %b want 1", one_minute); end
        tests++; if (pulses != 1) begin fails++; $display("FAIL wrap_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_set_time_wrap();
        int h0, mm0;
        set_time = 1'b1;
        @(negedge clk);
        h0 = m_h; mm0 = m_m;
        repeat (61) press(1'b0, 1'b1);
        tests++; if (current_time !== hhmm(h0, (mm0 + 1) % 60)) begin fails++; $display("FAIL min_wrap: got %h want %h", current_time, hhmm(h0, (mm0 + 1) % 60)); end
        repeat (24) press(1'b1, 1'b0);
        tests++; if (current_time !== hhmm(h0, (mm0 + 1) % 60)) begin fails++; $display("FAIL hour_wrap: got %h want %h", current_time, hhmm(h0, (mm0 + 1) % 60)); end
        set_time = 1'b0;
    endtask

    task automatic test_alarm_both();
        do_reset();
        repeat (3) @(negedge clk);
        set_alarm = 1'b1;
        inc_hour = 1'b1; inc_min = 1'b1;
        @(negedge clk);
        tests++; if (alarm_time !== 16'h0701) begin fails++; $display("FAIL alarm_both: got %h want 0701", alarm_time); end
        inc_hour = 1'b0; inc_min = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        tests++; if (seconds !== bcd(m_s) || m_s == 0) begin fails++; $display("FAIL alarm_running: got %h want %h", seconds, bcd(m_s)); end
        repeat (300) begin
            @(negedge clk);
            tests++;
            if (alarm_time !== hhmm(m_ah, m_am) || current_time !== hhmm(m_h, m_m) || seconds !== bcd(m_s)) begin
                fails++;
                $display("FAIL alarm_rand: got %h/%h/%h want %h/%h/%h", alarm_time, current_time, seconds,
                         hhmm(m_ah, m_am), hhmm(m_h, m_m), bcd(m_s));
            end
            inc_hour = ($urandom % 3) == 0;
            inc_min = ($urandom % 3) == 0;
        end
        inc_hour = 1'b0; inc_min = 1'b0; set_alarm = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_both_modes();
        int h0, mm0, ah0, am0;
        set_time = 1'b1; set_alarm = 1'b1;
        @(negedge clk);
        h0 = m_h; mm0 = m_m; ah0 = m_ah; am0 = m_am;
        press(1'b0, 1'b1);
        tests++; if (current_time !== hhmm(h0, (mm0 + 1) % 60)) begin fails++; $display("FAIL both_time: got %h want %h", current_time, hhmm(h0, (mm0 + 1) % 60)); end
        tests++; if (alarm_time !== hhmm(ah0, am0)) begin fails++; $display("FAIL both_alarm: got %h want %h", alarm_time, hhmm(ah0, am0)); end
        inc_min = 1'b1;
        repeat (20) @(negedge clk);
        inc_min = 1'b0;
        @(negedge clk);
        tests++; if (current_time !== hhmm(h0, (mm0 + 2) % 60)) begin fails++; $display("FAIL held_once: got %h want %h", current_time, hhmm(h0, (mm0 + 2) % 60)); end
        set_time = 1'b0; set_alarm = 1'b0;
    endtask

    task automatic test_held_through_reset();
        inc_min = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_time = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (current_time !== 16'h0000) begin fails++; $display("FAIL held_reset: got %h want 0000", current_time); end
        inc_min = 1'b0;
        @(negedge clk);
        inc_min = 1'b1;
        @(negedge clk);
        tests++; if (current_time !== 16'h0001) begin fails++; $display("FAIL repress: got %h want 0001", current_time); end
        inc_min = 1'b0; set_time = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_alarm = 1'b1;
        press(1'b1, 1'b1);
        set_alarm = 1'b0;
        set_time = 1'b1;
        @(negedge clk);
        repeat (12) press(1'b1, 1'b0);
        repeat (34) press(1'b0, 1'b1);
        set_time = 1'b0;
        repeat (56 * DIV) @(negedge clk);
        tests++; if (current_time !== 16'h1234 || seconds !== 8'h56) begin fails++; $display("FAIL mid_preset: got %h:%h want 1234:56", current_time, seconds); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if (current_time !== 16'h0000) begin fails++; $display("FAIL mid_time: got %h want 0000", current_time); end
        tests++; if (seconds !== 8'h00) begin fails++; $display("FAIL mid_sec: got %h want 00", seconds); end
        tests++; if (alarm_time !== 16'h0600) begin fails++; $display("FAIL mid_alarm: got %h want 0600", alarm_time); end
        tests++; if (one_minute !== 1'b0) begin fails++; $display("FAIL mid_pulse: got %b want 0", one_minute); end
    endtask

    task automatic test_random();
        int mode = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            tests++;
            if (current_time !== hhmm(m_h, m_m) || seconds !== bcd(m_s) ||
                alarm_time !== hhmm(m_ah, m_am) || one_minute !== m_pulse) begin
                fails++;
                $display("FAIL random: got %h %h %h %b want %h %h %h %b", current_time, seconds, alarm_time,
                         one_minute, hhmm(m_h, m_m), bcd(m_s), hhmm(m_ah, m_am), m_pulse);
            end
            if (i % 50 == 0) mode = $urandom % 4;
            set_time = mode == 1 || mode == 3;
            set_alarm = mode >= 2;
            inc_hour = ($urandom % 4) == 0;
            inc_min = ($urandom % 4) == 0;
            reset = ($urandom % 400) == 0;
        end
        reset = 1'b0; set_time = 1'b0; set_alarm = 1'b0; inc_hour = 1'b0; inc_min = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_run_minute();
        test_rollover();
        test_set_time_wrap();
        test_alarm_both();
        test_both_modes();
        test_held_through_reset();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
